// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute / write-back stage downstream of the DOF register.
//   clk, reset(async active-low)   clock and reset
//   in_valid + operand/control     DOF-latched instruction fields
//   stall                          holds IF/DOF while a memory op is pending
//   dmem_*                         req/ack data-memory transaction
//   wb_RW/wb_DA/wb_data            registered register-file write-back
//   br_taken/br_target             one-cycle branch pulse and destination
//   flag_Z/flag_N                  zero / sign of the last FU result
module ex_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] bus_A,
    input  logic [DATA_W-1:0] bus_B,
    input  logic [4:0]        FS,
    input  logic [4:0]        SH,
    input  logic [1:0]        MD,
    input  logic              RW,
    input  logic [4:0]        DA,
    input  logic              MW,
    input  logic [1:0]        BS,
    input  logic              PS,
    input  logic [DATA_W-1:0] PC_2,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_RW,
    output logic [4:0]        wb_DA,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              flag_Z,
    output logic              flag_N
);
    typedef enum logic {S_IDLE, S_MEM} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_rw_q, mem_rw_d;
    logic [4:0]        mem_da_q, mem_da_d;
    logic              wb_rw_q, wb_rw_d;
    logic [4:0]        wb_da_q, wb_da_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              br_taken_q, br_taken_d;
    logic [DATA_W-1:0] br_target_q, br_target_d;
    logic              z_q, z_d, n_q, n_d;

    // Function unit
    logic [DATA_W-1:0] sum_add, sum_sub, fu_res, slt_res, pc_rel;
    logic              v_sub, mem_op;

    always_comb begin
        sum_add = bus_A + bus_B;
        sum_sub = bus_A + ~bus_B + {{(DATA_W-1){1'b0}}, 1'b1};
        // Signed overflow of A-B: operands differ in sign and the result
        // sign differs from A.
        v_sub   = (bus_A[DATA_W-1] != bus_B[DATA_W-1]) &&
                  (sum_sub[DATA_W-1] != bus_A[DATA_W-1]);
        slt_res = {{(DATA_W-1){1'b0}}, sum_sub[DATA_W-1] ^ v_sub};
        pc_rel  = PC_2 + bus_B;
        mem_op  = (MD == 2'b01) || MW;
        case (FS)
            5'b00000: fu_res = bus_A;
            5'b00001: fu_res = bus_A + {{(DATA_W-1){1'b0}}, 1'b1};
            5'b00010: fu_res = sum_add;
            5'b00101: fu_res = sum_sub;
            5'b00110: fu_res = bus_A - {{(DATA_W-1){1'b0}}, 1'b1};
            5'b01000: fu_res = bus_A & bus_B;
            5'b01010: fu_res = bus_A | bus_B;
            5'b01100: fu_res = bus_A ^ bus_B;
            5'b01110: fu_res = ~bus_A;
            5'b10000: fu_res = bus_B;
            5'b10100: fu_res = bus_B >> SH;
            5'b11000: fu_res = bus_B << SH;
            default:  fu_res = '0;
        endcase
    end

    // Next-state / control
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_da_d    = mem_da_q;
        wb_rw_d     = 1'b0;  // strobes are single-cycle
        wb_da_d     = wb_da_q;
        wb_data_d   = wb_data_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        z_d         = z_q;
        n_d         = n_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (BS)
                        2'b01: if ((bus_A == '0) ^ PS) begin
                            br_taken_d  = 1'b1;
                            br_target_d = pc_rel;
                        end
                        2'b10: begin
                            br_taken_d  = 1'b1;
                            br_target_d = bus_A;
                        end
                        2'b11: begin
                            br_taken_d  = 1'b1;
                            br_target_d = pc_rel;
                        end
                        default: ;
                    endcase
                    if (MD != 2'b01) begin
                        z_d = (fu_res == '0);
                        n_d = fu_res[DATA_W-1];
                    end
                    if (mem_op) begin
                        addr_d   = bus_A[ADDR_W-1:0];
                        wdata_d  = bus_B;
                        mem_da_d = DA;
                        mem_rw_d = RW;
                        req_d    = 1'b1;
                        we_d     = MW;  // MW wins over MD=01
                        state_d  = S_MEM;
                    end else begin
                        wb_rw_d   = RW;
                        wb_da_d   = DA;
                        wb_data_d = (MD == 2'b10) ? slt_res : fu_res;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    if (!we_q) begin
                        wb_rw_d   = mem_rw_q;
                        wb_da_d   = mem_da_q;
                        wb_data_d = dmem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_rw_q    <= 1'b0;
            mem_da_q    <= '0;
            wb_rw_q     <= 1'b0;
            wb_da_q     <= '0;
            wb_data_q   <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_da_q    <= mem_da_d;
            wb_rw_q     <= wb_rw_d;
            wb_da_q     <= wb_da_d;
            wb_data_q   <= wb_data_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            z_q         <= z_d;
            n_q         <= n_d;
        end
    end

    assign stall      = (state_q == S_MEM);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_RW      = wb_rw_q;
    assign wb_DA      = wb_da_q;
    assign wb_data    = wb_data_q;
    assign br_taken   = br_taken_q;
    assign br_target  = br_target_q;
    assign flag_Z     = z_q;
    assign flag_N     = n_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
    logic [31:0] bus_A = '0, bus_B = '0, PC_2 = '0;
    logic [4:0]  FS = '0, SH = '0, DA = '0;
    logic [1:0]  MD = '0, BS = '0;
    logic        RW = 1'b0, MW = 1'b0, PS = 1'b0;
    logic        stall, dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata = '0;
    logic        wb_RW, br_taken, flag_Z, flag_N;
    logic [4:0]  wb_DA;
    logic [31:0] wb_data, br_target;

    ex_wb_stage #(.DATA_W(32), .ADDR_W(14)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .bus_A(bus_A), .bus_B(bus_B),
        .FS(FS), .SH(SH), .MD(MD), .RW(RW), .DA(DA), .MW(MW), .BS(BS), .PS(PS),
        .PC_2(PC_2), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_RW(wb_RW), .wb_DA(wb_DA), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .flag_Z(flag_Z), .flag_N(flag_N));

    always #5 clk = ~clk;

    typedef struct { logic [4:0] da; logic [31:0] data; } wb_t;
    wb_t         wb_q[$];
    logic [31:0] br_q[$];
    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction presented for a single accepting edge.
    task automatic issue(input logic [31:0] a, b, input logic [4:0] fs, sh,
                         input logic [1:0] md, input logic rw, input logic [4:0] da,
                         input logic mw, input logic [1:0] bs, input logic ps,
                         input logic [31:0] pc);
        bus_A = a; bus_B = b; FS = fs; SH = sh; MD = md; RW = rw; DA = da;
        MW = mw; BS = bs; PS = ps; PC_2 = pc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: consumes expectations whenever the DUT strobes a result.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (wb_RW) begin
                    if (wb_q.size() == 0) chk("unexpected_wb", {27'd0, wb_DA}, 32'hFFFF_FFFF);
                    else begin
                        wb_t e;
                        e = wb_q.pop_front();
                        chk("wb_DA", {27'd0, wb_DA}, {27'd0, e.da});
                        chk("wb_data", wb_data, e.data);
                    end
                end
                if (br_taken) begin
                    if (br_q.size() == 0) chk("unexpected_br", br_target, 32'hFFFF_FFFF);
                    else chk("br_target", br_target, br_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1;
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_req", {31'd0, dmem_req}, 0);
        chk("rst_wb", {31'd0, wb_RW}, 0);
        chk("rst_addr", {18'd0, dmem_addr}, 0);
        chk("rst_flags", {30'd0, flag_Z, flag_N}, 0);
        #11 reset = 1'b1;
        step();

        // ALU / SLT / shifts
        wb_q.push_back('{5'd3, 32'h8000_0000});
        issue(32'h7FFF_FFFF, 32'd1, 5'b00010, 5'd0, 2'b00, 1, 5'd3, 0, 2'b00, 0, 0);
        chk("flag_N_add", {31'd0, flag_N}, 1);
        chk("flag_Z_add", {31'd0, flag_Z}, 0);
        wb_q.push_back('{5'd4, 32'h0});
        issue(32'h7FFF_FFFF, 32'd1, 5'b00101, 5'd0, 2'b10, 1, 5'd4, 0, 2'b00, 0, 0);
        wb_q.push_back('{5'd5, 32'h0F00_0000});
        issue(0, 32'hF000_0000, 5'b10100, 5'd4, 2'b00, 1, 5'd5, 0, 2'b00, 0, 0);
        wb_q.push_back('{5'd6, 32'h8000_0000});
        issue(0, 32'd3, 5'b11000, 5'd31, 2'b00, 1, 5'd6, 0, 2'b00, 0, 0);
        wb_q.push_back('{5'd8, 32'h0});
        issue(32'h1234, 32'h5678, 5'b11111, 5'd0, 2'b00, 1, 5'd8, 0, 2'b00, 0, 0);
        chk("flag_Z_zero", {31'd0, flag_Z}, 1);
        wb_q.push_back('{5'd9, 32'hFFFF_FFFE});
        issue(32'd5, 32'd7, 5'b00101, 5'd0, 2'b00, 1, 5'd9, 0, 2'b00, 0, 0);
        wb_q.push_back('{5'd10, 32'd1});
        issue(32'd5, 32'd7, 5'b00101, 5'd0, 2'b10, 1, 5'd10, 0, 2'b00, 0, 0);
        // RW=0 op must not strobe
        issue(32'd1, 32'd1, 5'b00010, 5'd0, 2'b00, 0, 5'd11, 0, 2'b00, 0, 0);
        // Ack while idle is ignored
        dmem_ack = 1'b1; step(); dmem_ack = 1'b0;
        chk("idle_ack_req", {30'd0, dmem_req, stall}, 0);

        // Load with ack withheld three cycles; in_valid garbage must be ignored
        wb_q.push_back('{5'd7, 32'hDEAD_BEEF});
        issue(32'h0001_2345, 32'd0, 5'b00000, 5'd0, 2'b01, 1, 5'd7, 0, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ld_req", {29'd0, dmem_req, dmem_we, stall}, 32'b101);
            chk("ld_addr", {18'd0, dmem_addr}, 32'h2345);
            bus_A = 32'h3FFF; FS = 5'b00010; MD = 2'b00; RW = 1; DA = 5'd9; BS = 2'b10;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        chk("ld_hold", {29'd0, dmem_req, dmem_we, stall}, 32'b101);
        chk("ld_addr_hold", {18'd0, dmem_addr}, 32'h2345);
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 1'b0;
        chk("ld_done", {30'd0, dmem_req, stall}, 0);

        // Store acked in first request cycle
        issue(32'd5, 32'hA5, 5'b00000, 5'd0, 2'b00, 1, 5'd12, 1, 2'b00, 0, 0);
        chk("st_req", {29'd0, dmem_req, dmem_we, stall}, 32'b111);
        chk("st_wdata", dmem_wdata, 32'hA5);
        chk("st_addr", {18'd0, dmem_addr}, 32'd5);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("st_done", {30'd0, dmem_req, stall}, 0);
        chk("st_wb", {31'd0, wb_RW}, 0);

        // Branches
        br_q.push_back(32'd8);
        issue(32'd0, 32'hFFFF_FFFE, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 2'b01, 0, 32'd10);
        chk("br_pulse", {31'd0, br_taken}, 1);
        issue(32'd1, 32'hFFFF_FFFE, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 2'b01, 0, 32'd10);
        chk("br_not", {31'd0, br_taken}, 0);
        chk("br_target_hold", br_target, 32'd8);
        br_q.push_back(32'h40);
        issue(32'h40, 32'd0, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 2'b10, 0, 32'd10);
        br_q.push_back(32'h104);
        issue(32'd0, 32'd4, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 2'b11, 0, 32'h100);
        br_q.push_back(32'h203);
        issue(32'd3, 32'd3, 5'd0, 5'd0, 2'b00, 0, 5'd0, 0, 2'b01, 1, 32'h200);
        step();
        chk("br_end", {31'd0, br_taken}, 0);

        // Reset in the middle of a load
        issue(32'h10, 32'd0, 5'd0, 5'd0, 2'b01, 1, 5'd13, 0, 2'b00, 0, 0);
        chk("mid_req", {30'd0, dmem_req, stall}, 32'b11);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst", {29'd0, dmem_req, stall, wb_RW}, 0);
        step();
        #2 reset = 1'b1;
        step(); step();
        chk("post_rst", {30'd0, dmem_req, stall}, 0);

        step();
        chk("wb_q_empty", wb_q.size(), 0);
        chk("br_q_empty", br_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
